// File: rtl/dc_hex_ascii_ser.sv
// rtl/dc_hex_ascii_ser.sv - serial hex-to-ASCII string emitter
module dc_hex_ascii_ser #(
    parameter int DATA_W    = 32,
    parameter int PREFIX_EN = 1,
    parameter int EOL_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              lz_sup,
    input  logic              lower,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy
);

    localparam int NIB = DATA_W / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_width
        $error("dc_hex_ascii_ser: DATA_W must be a multiple of 4 and at least 4");
    end

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIG, CR, LF} state_t;

    state_t            state;
    state_t            nxt_state;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_src;
    logic              lower_q;
    logic              lower_src;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     nxt_idx;
    logic [IW-1:0]     lz_idx;
    logic [3:0]        nib;
    logic [7:0]        nxt_char;
    logic              nxt_last;
    logic              accept;
    logic              adv;

    function automatic logic [7:0] hex_char(input logic [3:0] n, input logic lc);
        if (n <= 4'd9)
            return 8'h30 + {4'h0, n};
        else
            return (lc ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid && in_ready;
    assign adv      = out_valid && out_ready;

    // On the accept cycle the word register is not loaded yet, so the first
    // character is built straight from the input.
    assign word_src  = accept ? in_data : word_q;
    assign lower_src = accept ? lower : lower_q;

    always_comb begin
        lz_idx = '0;
        for (int i = 0; i < NIB; i++) begin
            if (in_data[i*4 +: 4] != 4'h0)
                lz_idx = IW'(i);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx_q;
        case (state)
            IDLE: if (accept) begin
                nxt_idx   = lz_sup ? lz_idx : IW'(NIB - 1);
                nxt_state = (PREFIX_EN != 0) ? PFX0 : DIG;
            end
            PFX0: if (adv) nxt_state = PFX1;
            PFX1: if (adv) nxt_state = DIG;
            DIG: if (adv) begin
                if (idx_q == '0)
                    nxt_state = (EOL_EN != 0) ? CR : IDLE;
                else
                    nxt_idx = idx_q - 1'b1;
            end
            CR: if (adv) nxt_state = LF;
            LF: if (adv) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    assign nib = word_src[nxt_idx*4 +: 4];

    always_comb begin
        nxt_char = 8'h00;
        case (nxt_state)
            PFX0:    nxt_char = 8'h30;
            PFX1:    nxt_char = 8'h78;
            DIG:     nxt_char = hex_char(nib, lower_src);
            CR:      nxt_char = 8'h0D;
            LF:      nxt_char = 8'h0A;
            default: nxt_char = 8'h00;
        endcase
    end

    assign nxt_last = (nxt_state == LF) ||
                      (nxt_state == DIG && nxt_idx == '0 && EOL_EN == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            lower_q   <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            state <= nxt_state;
            idx_q <= nxt_idx;
            if (accept) begin
                word_q  <= in_data;
                lower_q <= lower;
            end
            // Outputs only move on accept or handshake, so they hold during stalls.
            if (accept || adv) begin
                out_valid <= (nxt_state != IDLE);
                out_char  <= nxt_char;
                out_last  <= nxt_last;
            end
        end
    end

endmodule

// File: tb/tb_dc_hex_ascii_ser.sv
// tb/tb_dc_hex_ascii_ser.sv - bench for dc_hex_ascii_ser (16-bit and 8-bit configs)
module tb_dc_hex_ascii_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_data16 = '0;
    logic        lz16 = 1'b0;
    logic        lo16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [7:0]  out_char16;
    logic        out_last16;
    logic        busy16;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_data8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  out_char8;
    logic        out_last8;
    logic        busy8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs16 = 0;
    int hs8 = 0;
    int hs8_cyc[4];
    bit rand_mode = 1'b0;

    logic [8:0] q16[$];
    logic [8:0] q8[$];

    bit         prev_stall16 = 1'b0;
    logic [7:0] prev_char16;
    logic       prev_last16;

    typedef struct {
        logic [15:0] d;
        logic        lz;
        logic        lo;
        int          len;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    dc_hex_ascii_ser #(.DATA_W(16), .PREFIX_EN(1), .EOL_EN(1)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .lz_sup(lz16), .lower(lo16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_char(out_char16),
        .out_last(out_last16), .busy(busy16)
    );

    dc_hex_ascii_ser #(.DATA_W(8), .PREFIX_EN(0), .EOL_EN(0)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .lz_sup(1'b0), .lower(1'b0),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_char(out_char8),
        .out_last(out_last8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready16 = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the 16-bit instance, plus stall-stability tracking.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall16 = 1'b0;
        end else begin
            if (prev_stall16) begin
                chk("stall_valid", 32'(out_valid16), 32'd1);
                chk("stall_char", 32'(out_char16), 32'(prev_char16));
                chk("stall_last", 32'(out_last16), 32'(prev_last16));
            end
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0)
                    chk("unexpected_char16", 32'(out_char16), 32'h1ff);
                else
                    chk("char16", 32'({out_last16, out_char16}), 32'(q16.pop_front()));
                hs16++;
            end
            prev_stall16 = out_valid16 && !out_ready16;
            prev_char16  = out_char16;
            prev_last16  = out_last16;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0)
                chk("unexpected_char8", 32'(out_char8), 32'h1ff);
            else
                chk("char8", 32'({out_last8, out_char8}), 32'(q8.pop_front()));
            if (hs8 < 4) hs8_cyc[hs8] = cyc;
            hs8++;
        end
    end

    task automatic push_exp(input logic [63:0] e, input int len);
        for (int i = 0; i < len; i++)
            q16.push_back({(i == len - 1), e[63 - 8*i -: 8]});
    endtask

    task automatic wait_idle16(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready16) break;
            n++;
            if (n > 500) begin
                chk(name, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        push_exp(v.exp, v.len);
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_data16 = v.d; lz16 = v.lz; lo16 = v.lo;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready16) break;
            n++;
            if (n > 100) break;
        end
        chk("str_cycles", 32'(n), 32'(v.len));
        chk("drain16", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        vecs[0] = '{16'h1A2F, 1'b0, 1'b0, 8, 64'h3078_3141_3246_0D0A};
        vecs[1] = '{16'h00B0, 1'b1, 1'b1, 6, 64'h3078_6230_0D0A_0000};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, 5, 64'h3078_300D_0A00_0000};
        vecs[3] = '{16'h0000, 1'b0, 1'b0, 8, 64'h3078_3030_3030_0D0A};
        vecs[4] = '{16'h0ABC, 1'b0, 1'b1, 8, 64'h3078_3061_6263_0D0A};
        vecs[5] = '{16'h00B0, 1'b1, 1'b0, 6, 64'h3078_4230_0D0A_0000};
        vecs[6] = '{16'h8000, 1'b1, 1'b0, 8, 64'h3078_3830_3030_0D0A};
        vecs[7] = '{16'h0001, 1'b1, 1'b1, 5, 64'h3078_310D_0A00_0000};

        #3;
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_out_char", 32'(out_char16), 32'h00);
        chk("rst_out_last", 32'(out_last16), 32'd0);
        chk("rst_in_ready", 32'(in_ready16), 32'd1);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure with a second word waiting on the input.
        push_exp(64'h3078_4646_4646_0D0A, 8);
        push_exp(64'h3078_3132_3334_0D0A, 8);
        rand_mode = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_data16 = 16'hFFFF; lz16 = 1'b0; lo16 = 1'b0;
        @(posedge clk); #1;
        base = hs16;
        in_data16 = 16'h1234;
        wait_idle16("bp_timeout1");
        chk("accept2_after_lf", 32'(hs16 - base), 32'd8);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        wait_idle16("bp_timeout2");
        rand_mode = 1'b0;
        chk("bp_drain", 32'(q16.size()), 32'd0);

        // Reset after the third character handshake.
        push_exp(64'h3078_3100_0000_0000, 3);
        q16[2] = {1'b0, 8'h31};
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_data16 = 16'h1A2F; lz16 = 1'b0; lo16 = 1'b0;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        base = hs16;
        n = 0;
        while (hs16 != base + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("rst_reach3", 32'(hs16 - base), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid16), 32'd0);
        chk("midrst_in_ready", 32'(in_ready16), 32'd1);
        chk("midrst_busy", 32'(busy16), 32'd0);
        chk("midrst_queue", 32'(q16.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec('{16'h0001, 1'b0, 1'b0, 8, 64'h3078_3030_3031_0D0A});

        // 8-bit, no prefix/EOL, back-to-back words.
        q8.push_back({1'b0, 8'h37});
        q8.push_back({1'b1, 8'h45});
        q8.push_back({1'b0, 8'h43});
        q8.push_back({1'b1, 8'h33});
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 8'h7E;
        @(posedge clk); #1;
        in_data8 = 8'hC3;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready8 || n > 100) break;
            n++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (hs8 < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("hs8_count", 32'(hs8), 32'd4);
        chk("hs8_gap01", 32'(hs8_cyc[1] - hs8_cyc[0]), 32'd1);
        chk("hs8_gap12", 32'(hs8_cyc[2] - hs8_cyc[1]), 32'd2);
        chk("hs8_gap23", 32'(hs8_cyc[3] - hs8_cyc[2]), 32'd1);
        chk("drain8", 32'(q8.size()), 32'd0);
        @(negedge clk);
        chk("idle8", 32'(in_ready8), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_hex_ascii_ser.md
Name: dc_hex_ascii_ser

Overview:
Parametrised serial hex-to-ASCII string emitter. It accepts one DATA_W-bit word over a valid/ready handshake and streams its hexadecimal text representation one ASCII character per output handshake. The text has an optional "0x" prefix, optional leading-zero suppression, an upper/lower-case digit mode and an optional CR/LF terminator. It sits between status/debug registers and a UART TX or character FIFO.

Parameters:
DATA_W, 32, input word width in bits; must be a multiple of 4 and at least 4 (otherwise an elaboration error); NIB = DATA_W/4 digits.
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits.
EOL_EN, 1, 1 = emit CR, LF (0x0D, 0x0A) after the digits.

Ports:
CLK  in  1  clock, all state updates on its rising edge
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  IN_DATA/LZ_SUP/LOWER valid
IN_READY  out  1  block can accept a word
IN_DATA  in  DATA_W  word to convert
LZ_SUP  in  1  suppress leading zero nibbles (sampled at accept)
LOWER  in  1  1 = digits a-f as 0x61-0x66, 0 = A-F as 0x41-0x46 (sampled at accept)
OUT_VALID  out  1  OUT_CHAR valid
OUT_READY  in  1  downstream accepts the character
OUT_CHAR  out  8  ASCII character
OUT_LAST  out  1  OUT_CHAR is the final character of the string
BUSY  out  1  string in progress (equals !IN_READY)

Behaviour:
- Clocking and reset:
  - Single clock CLK; RST is asynchronous and active-high.
  - Reset values: state IDLE, OUT_VALID=0, OUT_CHAR=8'h00, OUT_LAST=0, IN_READY=1, BUSY=0.
- States: IDLE, PFX0, PFX1, DIG, CR, LF.
- IN_READY is combinational, equal to (state==IDLE). An accept occurs when IN_VALID && IN_READY.
- On accept:
  - Register the word, LZ_SUP and LOWER.
  - Set the digit index to NIB-1 (MSB nibble). If LZ_SUP=1, set it instead to the index of the most significant non-zero nibble; an all-zero word uses index 0, so exactly one '0' is emitted.
  - Next state is PFX0 if PREFIX_EN, else DIG.
  - The first character appears with OUT_VALID=1 on the cycle after accept.
- Outputs are registered. OUT_CHAR and OUT_LAST hold stable while OUT_VALID && !OUT_READY. Advance only on OUT_VALID && OUT_READY.
- Characters per state:
  - PFX0: 0x30. PFX1: 0x78 ('x' is always lower case).
  - DIG, digit value n: n<=9 gives 0x30+n; n>=10 gives 0x41+n-10 (LOWER=0) or 0x61+n-10 (LOWER=1).
  - CR: 0x0D. LF: 0x0A.
- Transitions, each taken on a handshake:
  - PFX0 -> PFX1 -> DIG.
  - In DIG the index decrements; at index 0 go to CR if EOL_EN, else IDLE.
  - CR -> LF -> IDLE.
- OUT_LAST=1 only on the final character: LF if EOL_EN, else the index-0 digit.
- Throughput:
  - One character per cycle while OUT_READY is held high.
  - After the final handshake, OUT_VALID=0 and IN_READY=1 on the next cycle. Minimum gap between strings is one accept cycle.
- IN_VALID while busy is ignored; the word is not consumed and must be held by the source.
- RST mid-string: abort immediately (OUT_VALID drops asynchronously). No partial resume; the next accepted word starts a fresh string.
- String length is (PREFIX_EN?2:0) + digits + (EOL_EN?2:0), where digits = NIB, or 1..NIB under LZ_SUP.

Test Plan:
1. DATA_W=16, PREFIX_EN=1, EOL_EN=1; IN_DATA=16'h1A2F, LZ_SUP=0, LOWER=0, OUT_READY=1 -> 30 78 31 41 32 46 0D 0A on 8 consecutive cycles starting the cycle after accept; OUT_LAST only on 0A.
2. Same config; IN_DATA=16'h00B0, LZ_SUP=1, LOWER=1 -> 30 78 62 30 0D 0A.
3. Same config; IN_DATA=16'h0000, LZ_SUP=1 -> 30 78 30 0D 0A; LZ_SUP=0 -> 30 78 30 30 30 30 0D 0A.
4. Backpressure: IN_DATA=16'hFFFF with OUT_READY randomly toggled and IN_VALID held high with a second word -> sequence 30 78 46 46 46 46 0D 0A with no drop or duplicate; OUT_CHAR stable during stalls; second word accepted only after LF handshake.
5. RST asserted after the 3rd character handshake -> OUT_VALID=0 and IN_READY=1 immediately; after release, IN_DATA=16'h0001 yields a complete fresh 30 78 30 30 30 31 0D 0A.
6. DATA_W=8, PREFIX_EN=0, EOL_EN=0; back-to-back 8'h7E then 8'hC3 -> 37 45 (OUT_LAST on 45), then 43 33; second accept occurs one cycle after the 45 handshake.
